// File: rtl/debounce_bank_pkg.sv
// rtl/debounce_bank_pkg.sv - shared constants and counter decision helper for debounce_bank
package debounce_bank_pkg;

    localparam int unsigned BOARD_CLK_HZ        = 100_000_000;
    // 10 ms worth of 100 MHz clocks; board tops pass this as STABLE_CYCLES.
    localparam int unsigned DEBOUNCE_10MS_TICKS = BOARD_CLK_HZ / 100;

    typedef enum logic [1:0] {
        CNT_CLEAR  = 2'd0,
        CNT_INC    = 2'd1,
        CNT_COMMIT = 2'd2
    } cnt_action_e;

    function automatic cnt_action_e cnt_action(
        input logic s,
        input logic level,
        input logic at_limit
    );
        if (s == level) begin
            return CNT_CLEAR;
        end else if (at_limit) begin
            return CNT_COMMIT;
        end else begin
            return CNT_INC;
        end
    endfunction

endpackage

// File: rtl/debounce_bank_channel.sv
// rtl/debounce_bank_channel.sv - one debounce channel: synchroniser, stability counter, level and edge pulses
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    cnt_action_e            action;

    assign s      = sync[SYNC_STAGES-1];
    assign action = cnt_action(s, dout, cnt == CNT_LAST);

    // The synchroniser runs every clock so tick_en never widens metastability exposure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick_en) begin
                unique case (action)
                    CNT_CLEAR: cnt <= '0;
                    CNT_INC:   cnt <= cnt + CNT_W'(1);
                    CNT_COMMIT: begin
                        cnt  <= '0;
                        dout <= s;
                        rise <= s;
                        fall <= ~s;
                    end
                    default:   cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - WIDTH independent debounce channels with rise/fall pulses
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               SYNC_STAGES   = 2,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < 1) begin : g_bad_width
        $error("debounce_bank: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_bank: STABLE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_en (tick_en),
            .din     (din[i]),
            .dout    (dout[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank against a sample-history model
module tb_debounce_bank;

    localparam int       W    = 4;
    localparam int       SYNC = 2;
    localparam int       STB  = 4;
    localparam logic [W-1:0] RV = 4'h0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick_en = 1'b1;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout, rise, fall;

    int checks = 0;
    int errors = 0;

    debounce_bank #(
        .WIDTH         (W),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STB),
        .RESET_VAL     (RV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_en (tick_en),
        .din     (din),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall)
    );

    always #5 clk = ~clk;

    // Reference: din delayed SYNC edges; dout flips once the last STB ticked samples all disagree with it.
    logic [W-1:0] pipe[$];
    bit           hist[W][$];
    logic [W-1:0] m_dout, m_rise, m_fall;

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] s;
        bit           all_diff;
        if (!rst_n) begin
            pipe = {};
            for (int i = 0; i < SYNC; i++) pipe.push_back(RV);
            for (int ch = 0; ch < W; ch++) hist[ch] = {};
            m_dout = RV;
            m_rise = '0;
            m_fall = '0;
        end else begin
            s = pipe.pop_front();
            pipe.push_back(din);
            m_rise = '0;
            m_fall = '0;
            if (tick_en) begin
                for (int ch = 0; ch < W; ch++) begin
                    hist[ch].push_back(s[ch]);
                    if (hist[ch].size() > STB) void'(hist[ch].pop_front());
                    all_diff = (hist[ch].size() == STB);
                    for (int i = 0; i < hist[ch].size(); i++)
                        if (hist[ch][i] == m_dout[ch]) all_diff = 0;
                    if (all_diff) begin
                        m_dout[ch] = ~m_dout[ch];
                        if (m_dout[ch]) m_rise[ch] = 1'b1;
                        else            m_fall[ch] = 1'b1;
                        hist[ch] = {};
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        din = 4'hF;
        tick_en = 1'b1;
        repeat (10) step();
        checks++;
        if (dout !== 4'hF) begin
            errors++;
            $display("FAIL reset_pre_dout: got %h want %h", dout, 4'hF);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_async: got dout=%h rise=%h fall=%h want 0/0/0", dout, rise, fall);
        end
        @(negedge clk);
        din = 4'h0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        int edges = 0;
        do_reset();
        din = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if (fall !== 4'h0) begin
                errors++;
                $display("FAIL latency_fall: got %h want 0", fall);
            end
            if (dout[0]) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges != SYNC + STB) begin
            errors++;
            $display("FAIL latency_edges: got %0d want %0d", edges, SYNC + STB);
        end
        checks++;
        if (rise !== 4'b0001) begin
            errors++;
            $display("FAIL latency_rise: got %b want 0001", rise);
        end
        step();
        checks++;
        if (rise !== 4'b0000 || dout !== 4'b0001) begin
            errors++;
            $display("FAIL latency_after: got rise=%b dout=%b want 0000/0001", rise, dout);
        end
    endtask

    task automatic test_glitch();
        logic [10:0] pat = 11'b00001110111;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            din[1] = pat[i];
            step();
            checks++;
            if (dout[1] !== 1'b0 || rise[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject: step %0d got dout1=%b rise1=%b want 0/0", i, dout[1], rise[1]);
            end
        end
        din[1] = 1'b1;
        repeat (12) begin
            step();
            if (rise[1]) pulses++;
        end
        checks++;
        if (dout[1] !== 1'b1 || pulses != 1) begin
            errors++;
            $display("FAIL glitch_settle: got dout1=%b pulses=%0d want 1/1", dout[1], pulses);
        end
    endtask

    task automatic test_all_bits();
        bit seen = 0;
        do_reset();
        din = 4'hF;
        for (int k = 0; k < 30 && !seen; k++) begin
            step();
            if (dout !== 4'h0) seen = 1;
        end
        checks++;
        if (!seen || dout !== 4'hF || rise !== 4'hF || fall !== 4'h0) begin
            errors++;
            $display("FAIL all_rise: got dout=%h rise=%h fall=%h want F/F/0", dout, rise, fall);
        end
        step();
        checks++;
        if (rise !== 4'h0) begin
            errors++;
            $display("FAIL all_rise_width: got %h want 0", rise);
        end
        din = 4'h0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step();
            if (dout !== 4'hF) seen = 1;
        end
        checks++;
        if (!seen || dout !== 4'h0 || fall !== 4'hF || rise !== 4'h0) begin
            errors++;
            $display("FAIL all_fall: got dout=%h rise=%h fall=%h want 0/0/F", dout, rise, fall);
        end
        step();
        checks++;
        if (fall !== 4'h0) begin
            errors++;
            $display("FAIL all_fall_width: got %h want 0", fall);
        end
    endtask

    task automatic test_tick_gating();
        int edges = 0;
        do_reset();
        din[2] = 1'b1;
        tick_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick_en = (k % 4 == 0);
            step();
            if (dout[2]) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges != 16 || rise !== 4'b0100) begin
            errors++;
            $display("FAIL tick_latency: got edges=%0d rise=%b want 16/0100", edges, rise);
        end
        tick_en = 1'b0;
        step();
        checks++;
        if (rise !== 4'b0000 || dout[2] !== 1'b1) begin
            errors++;
            $display("FAIL tick_pulse_width: got rise=%b dout2=%b want 0000/1", rise, dout[2]);
        end
        tick_en = 1'b1;
    endtask

    task automatic test_reset_midcount();
        int edges = 0;
        do_reset();
        din[3] = 1'b1;
        repeat (SYNC + 3) step();
        checks++;
        if (dout[3] !== 1'b0) begin
            errors++;
            $display("FAIL midcount_pre: got %b want 0", dout[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 4'h0) begin
            errors++;
            $display("FAIL midcount_reset: got %h want 0", dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (dout[3]) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges != SYNC + STB) begin
            errors++;
            $display("FAIL midcount_restart: got %0d edges want %0d", edges, SYNC + STB);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick_en = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
            step();
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle %0d: got dout=%h rise=%h fall=%h want %h/%h/%h",
                             n, dout, rise, fall, m_dout, m_rise, m_fall);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din = '0;
        tick_en = 1'b1;
        #1;
        checks++;
        if (dout !== RV || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_initial: got dout=%h rise=%h fall=%h want 0/0/0", dout, rise, fall);
        end
        @(negedge clk);
        step();
        rst_n = 1'b1;
        test_reset();
        test_latency();
        test_glitch();
        test_all_bits();
        test_tick_gating();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
